// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write port arbiter: pipeline writeback vs queued mul/div results
// Optional stall_cycles counter when WB_PERF_CNT_EN is defined.
module wb_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int MC_DEPTH   = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_waddr,
  input  logic [DATA_W-1:0] pipe_wdata,
  input  logic              mc_valid,
  output logic              mc_ready,
  input  logic [ADDR_W-1:0] mc_waddr,
  input  logic [DATA_W-1:0] mc_wdata,
  output logic              pipe_stall,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              busy
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  localparam int PTR_W = (MC_DEPTH > 1) ? $clog2(MC_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ST_W  = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(MC_DEPTH);
  localparam logic [ST_W-1:0]  STARVE_C = ST_W'(STARVE_MAX);

  logic [ADDR_W-1:0] fifo_addr [MC_DEPTH];
  logic [DATA_W-1:0] fifo_data [MC_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [ST_W-1:0]   starve;

  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              pipe_req;
  logic              force_mc;
  logic              mc_grant;
  logic              pipe_grant;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_C);
  assign mc_ready   = !fifo_full;
  assign busy       = !fifo_empty;
  assign push       = mc_valid & mc_ready;
  assign head_addr  = fifo_addr[rd_ptr];
  assign head_data  = fifo_data[rd_ptr];

  // A same-address pipe write must wait: the queued MC result is older.
  assign pipe_req   = pipe_we & (pipe_waddr != '0);
  assign force_mc   = !fifo_empty &
                      ((starve == STARVE_C) | (pipe_req & (pipe_waddr == head_addr)));
  assign mc_grant   = force_mc | (!fifo_empty & !pipe_req);
  assign pipe_grant = pipe_req & !force_mc;
  assign pipe_stall = force_mc & pipe_req;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= mc_waddr;
      fifo_data[wr_ptr] <= mc_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      starve   <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (mc_grant) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, mc_grant})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      if (fifo_empty || mc_grant) begin
        starve <= '0;
      end else if (starve != STARVE_C) begin
        starve <= starve + ST_W'(1);
      end

      // An address-0 MC entry is popped without issuing a write.
      if (mc_grant) begin
        rf_we <= (head_addr != '0);
        if (head_addr != '0) begin
          rf_waddr <= head_addr;
          rf_wdata <= head_data;
        end
      end else if (pipe_grant) begin
        rf_we    <= 1'b1;
        rf_waddr <= pipe_waddr;
        rf_wdata <= pipe_wdata;
      end else begin
        rf_we <= 1'b0;
      end
    end
  end

`ifdef WB_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (pipe_stall && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - self-checking bench for wb_port_arbiter
// Directed vector table, hand sequences (full FIFO, mid-queue reset) and random traffic vs a queue model.
module tb_wb_port_arbiter;

  localparam int DEPTH  = 2;
  localparam int SMAX   = 4;

  logic        clk;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        mc_valid;
  logic        mc_ready;
  logic [4:0]  mc_waddr;
  logic [31:0] mc_wdata;
  logic        pipe_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        busy;
`ifdef WB_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  wb_port_arbiter #(
    .DATA_W(32), .ADDR_W(5), .MC_DEPTH(DEPTH), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_waddr(mc_waddr), .mc_wdata(mc_wdata),
    .pipe_stall(pipe_stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy)
`ifdef WB_PERF_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  int          m_starve;
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  int          m_stalls;

  typedef struct {
    logic        pw;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic        e_stall;
    logic        e_busy;
    logic        e_ready;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
  } vec_t;

  vec_t tbl[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_starve = 0;
    m_we     = 1'b0;
    m_wa     = '0;
    m_wd     = '0;
    m_stalls = 0;
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic step(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                      input logic mv, input logic [4:0] ma, input logic [31:0] md,
                      output logic o_stall, output logic o_busy, output logic o_ready);
    logic preq, ne, frc, rdy;
    pipe_we = pw; pipe_waddr = pa; pipe_wdata = pd;
    mc_valid = mv; mc_waddr = ma; mc_wdata = md;
    #4;
    preq = pw && (pa != 0);
    ne   = (q.size() != 0);
    frc  = ne && ((m_starve == SMAX) || (preq && (pa == q[0].a)));
    rdy  = (q.size() < DEPTH);
    check("pipe_stall", pipe_stall, frc && preq);
    check("mc_ready", mc_ready, rdy);
    check("busy", busy, ne);
    o_stall = pipe_stall; o_busy = busy; o_ready = mc_ready;

    if (frc || (ne && !preq)) begin
      if (q[0].a != 0) begin
        m_we = 1'b1; m_wa = q[0].a; m_wd = q[0].d;
      end else begin
        m_we = 1'b0;
      end
      void'(q.pop_front());
      m_starve = 0;
    end else if (preq) begin
      m_we = 1'b1; m_wa = pa; m_wd = pd;
      m_starve = ne ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
    end else begin
      m_we = 1'b0;
      m_starve = 0;
    end
    if (mv && rdy) q.push_back('{a: ma, d: md});
    if (frc && preq) m_stalls++;

    @(posedge clk);
    #1;
    check("rf_we", rf_we, m_we);
    check("rf_waddr", rf_waddr, m_wa);
    check("rf_wdata", rf_wdata, m_wd);
`ifdef WB_PERF_CNT_EN
    check("stall_cycles", stall_cycles, m_stalls);
`endif
  endtask

  task automatic idle_inputs();
    pipe_we = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
    mc_valid = 1'b0; mc_waddr = '0; mc_wdata = '0;
  endtask

  // Asserted mid-cycle to exercise the asynchronous path.
  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_rf_we", rf_we, 1'b0);
    check("rst_rf_waddr", rf_waddr, 5'd0);
    check("rst_rf_wdata", rf_wdata, 32'd0);
    check("rst_mc_ready", mc_ready, 1'b1);
    check("rst_pipe_stall", pipe_stall, 1'b0);
`ifdef WB_PERF_CNT_EN
    check("rst_stall_cycles", stall_cycles, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    logic s, b, r;
    logic        pw;
    logic [4:0]  pa;
    logic [31:0] pd;

    rst = 1'b1;
    idle_inputs();
    model_clear();
    @(posedge clk);
    #1;
    apply_reset();

    //            pw   pa     pd            mv   ma     md          stl  bsy  rdy  we   wa     wd
    tbl[0]  = '{1'b1, 5'd3, 32'hA5,       1'b0, 5'd0, 32'h0,      1'b0,1'b0,1'b1,1'b1,5'd3, 32'hA5};
    tbl[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,      1'b0,1'b0,1'b1,1'b0,5'd3, 32'hA5};
    tbl[2]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h1234,   1'b0,1'b0,1'b1,1'b0,5'd3, 32'hA5};
    tbl[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,      1'b0,1'b1,1'b1,1'b1,5'd7, 32'h1234};
    tbl[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,      1'b0,1'b0,1'b1,1'b0,5'd7, 32'h1234};
    tbl[5]  = '{1'b1, 5'd2, 32'h20,       1'b1, 5'd9, 32'h99,     1'b0,1'b0,1'b1,1'b1,5'd2, 32'h20};
    tbl[6]  = '{1'b1, 5'd2, 32'h21,       1'b0, 5'd0, 32'h0,      1'b0,1'b1,1'b1,1'b1,5'd2, 32'h21};
    tbl[7]  = '{1'b1, 5'd2, 32'h22,       1'b0, 5'd0, 32'h0,      1'b0,1'b1,1'b1,1'b1,5'd2, 32'h22};
    tbl[8]  = '{1'b1, 5'd2, 32'h23,       1'b0, 5'd0, 32'h0,      1'b0,1'b1,1'b1,1'b1,5'd2, 32'h23};
    tbl[9]  = '{1'b1, 5'd2, 32'h24,       1'b0, 5'd0, 32'h0,      1'b0,1'b1,1'b1,1'b1,5'd2, 32'h24};
    tbl[10] = '{1'b1, 5'd2, 32'h25,       1'b0, 5'd0, 32'h0,      1'b1,1'b1,1'b1,1'b1,5'd9, 32'h99};
    tbl[11] = '{1'b1, 5'd2, 32'h25,       1'b0, 5'd0, 32'h0,      1'b0,1'b0,1'b1,1'b1,5'd2, 32'h25};
    tbl[12] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 32'h55,     1'b0,1'b0,1'b1,1'b0,5'd2, 32'h25};
    tbl[13] = '{1'b1, 5'd5, 32'h66,       1'b0, 5'd0, 32'h0,      1'b1,1'b1,1'b1,1'b1,5'd5, 32'h55};
    tbl[14] = '{1'b1, 5'd5, 32'h66,       1'b0, 5'd0, 32'h0,      1'b0,1'b0,1'b1,1'b1,5'd5, 32'h66};
    tbl[15] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,      1'b0,1'b0,1'b1,1'b0,5'd5, 32'h66};
    tbl[16] = '{1'b1, 5'd0, 32'h77,       1'b1, 5'd0, 32'h88,     1'b0,1'b0,1'b1,1'b0,5'd5, 32'h66};
    tbl[17] = '{1'b1, 5'd0, 32'h77,       1'b0, 5'd0, 32'h0,      1'b0,1'b1,1'b1,1'b0,5'd5, 32'h66};
    tbl[18] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,      1'b0,1'b0,1'b1,1'b0,5'd5, 32'h66};

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].pw, tbl[i].pa, tbl[i].pd, tbl[i].mv, tbl[i].ma, tbl[i].md, s, b, r);
      check($sformatf("tbl%0d_stall", i), s, tbl[i].e_stall);
      check($sformatf("tbl%0d_busy", i), b, tbl[i].e_busy);
      check($sformatf("tbl%0d_ready", i), r, tbl[i].e_ready);
      check($sformatf("tbl%0d_we", i), rf_we, tbl[i].e_we);
      check($sformatf("tbl%0d_waddr", i), rf_waddr, tbl[i].e_wa);
      check($sformatf("tbl%0d_wdata", i), rf_wdata, tbl[i].e_wd);
    end
`ifdef WB_PERF_CNT_EN
    check("tbl_stall_total", stall_cycles, 32'd2);
`endif

    // Fill the FIFO behind a busy pipeline, then reset with entries queued.
    step(1'b1, 5'd4, 32'h40, 1'b1, 5'd10, 32'hA0, s, b, r);
    step(1'b1, 5'd4, 32'h41, 1'b1, 5'd11, 32'hB0, s, b, r);
    step(1'b1, 5'd4, 32'h42, 1'b1, 5'd12, 32'hC0, s, b, r);
    check("full_ready_low", r, 1'b0);
    check("full_busy", b, 1'b1);
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, s, b, r);
      check("post_rst_no_write", rf_we, 1'b0);
    end

    // Random traffic; a stalled pipeline holds its request.
    pw = 1'b0; pa = '0; pd = '0; s = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!s) begin
        pw = ($urandom_range(0, 9) < 7);
        pa = 5'($urandom_range(0, 7));
        pd = $urandom;
      end
      step(pw, pa, pd, ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)), $urandom, s, b, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
